// File: rtl/gesture_classifier.sv
// Debounces a finger-status pattern, classifies it into a sign code and hands each new code out once
// over valid/ready. Define GESTURE_HOLD_CNT_EN to add the hold_cycles output.
module gesture_classifier #(
   parameter int NUM_FINGERS   = 5,
   parameter int CODE_W        = 4,
   parameter int STABLE_CYCLES = 8,
   parameter int CNT_W         = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [NUM_FINGERS-1:0] finger_status,
   output logic [CODE_W-1:0]      sign_value,
   output logic                   sign_valid,
   input  logic                   sign_ready
`ifdef GESTURE_HOLD_CNT_EN
   ,
   output logic [CNT_W-1:0]       hold_cycles
`endif
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_EMIT   = 2'd2;
   localparam logic [1:0] S_HOLD   = 2'd3;

   localparam logic [CODE_W-1:0] UNKNOWN     = '1;
   localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [1:0]             state;
   logic [NUM_FINGERS-1:0] sample_q;
   logic [CNT_W-1:0]       stable_cnt;
   logic [CODE_W-1:0]      last_code;

   logic                   same_sample;
   logic                   settle_done;
   logic                   accept;
   logic                   enter_hold;
   logic [CODE_W-1:0]      code_now;

   // A non-zero pattern is a single run of ones iff filling its trailing zeros yields 2**k-1.
   function automatic logic [CODE_W-1:0] classify(input logic [NUM_FINGERS-1:0] p);
      logic [NUM_FINGERS-1:0] filled;
      logic [CODE_W-1:0]      ones;
      filled = p | (p - NUM_FINGERS'(1));
      ones   = '0;
      for (int i = 0; i < NUM_FINGERS; i++) begin
         ones = ones + CODE_W'(p[i]);
      end
      if (p == '0) begin
         return '0;
      end else if (((filled + NUM_FINGERS'(1)) & filled) == '0) begin
         return ones;
      end else begin
         return UNKNOWN;
      end
   endfunction

   // The counter restarts on acceptance so a change made while EMIT was stalled still needs a full
   // debounce window; ">=" lets a pattern that was already stable on entry to SETTLE be accepted.
   always_comb begin
      same_sample = (finger_status == sample_q);
      code_now    = classify(sample_q);
      accept      = sign_valid & sign_ready;
      settle_done = (state == S_SETTLE) && same_sample && (stable_cnt >= SETTLE_LAST);
      enter_hold  = (enable && settle_done && (code_now == last_code)) ||
                    ((state == S_EMIT) && accept && enable);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_q   <= '0;
         stable_cnt <= '0;
         last_code  <= UNKNOWN;
         sign_value <= UNKNOWN;
         sign_valid <= 1'b0;
         state      <= S_IDLE;
      end else begin
         sample_q <= finger_status;
         if ((state == S_EMIT) && accept) begin
            stable_cnt <= '0;
         end else if (same_sample) begin
            stable_cnt <= (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + CNT_W'(1);
         end else begin
            stable_cnt <= '0;
         end

         case (state)
            S_IDLE: begin
               if (enable) state <= S_SETTLE;
            end
            S_SETTLE: begin
               if (!enable) begin
                  state <= S_IDLE;
               end else if (settle_done) begin
                  if (code_now != last_code) begin
                     sign_value <= code_now;
                     last_code  <= code_now;
                     sign_valid <= 1'b1;
                     state      <= S_EMIT;
                  end else begin
                     state <= S_HOLD;
                  end
               end
            end
            S_EMIT: begin
               if (accept) begin
                  sign_valid <= 1'b0;
                  state      <= enable ? S_HOLD : S_IDLE;
               end
            end
            S_HOLD: begin
               // A code that changed while EMIT was stalled also needs to be settled and sent.
               if (!enable) begin
                  state <= S_IDLE;
               end else if (!same_sample || (code_now != last_code)) begin
                  state <= S_SETTLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef GESTURE_HOLD_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cycles <= '0;
      end else if ((state != S_HOLD) && enter_hold) begin
         hold_cycles <= '0;
      end else if ((state == S_HOLD) && (hold_cycles != CNT_MAX)) begin
         hold_cycles <= hold_cycles + CNT_W'(1);
      end
   end
`else
   logic unused_enter_hold;
   assign unused_enter_hold = enter_hold;
`endif

endmodule

// File: tb/tb_gesture_classifier.sv
// Scoreboard bench for gesture_classifier with STABLE_CYCLES=4; expected codes are queued as stimulus
// is applied and checked at each valid/ready handshake.
module tb_gesture_classifier;

   localparam int NF = 5;
   localparam int CW = 4;
   localparam int N  = 4;
   localparam int CW_CNT = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic [NF-1:0] finger_status = '0;
   logic [CW-1:0] sign_value;
   logic          sign_valid;
   logic          sign_ready = 1'b1;
`ifdef GESTURE_HOLD_CNT_EN
   logic [CW_CNT-1:0] hold_cycles;
`endif

   int checks = 0;
   int errors = 0;
   logic [CW-1:0] exp_q[$];
   logic [CW-1:0] mon_exp;

   gesture_classifier #(
      .NUM_FINGERS(NF), .CODE_W(CW), .STABLE_CYCLES(N), .CNT_W(CW_CNT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .finger_status(finger_status),
      .sign_value(sign_value),
      .sign_valid(sign_valid),
      .sign_ready(sign_ready)
`ifdef GESTURE_HOLD_CNT_EN
      ,
      .hold_cycles(hold_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Scoreboard: a handshake happens at the next rising edge whenever valid & ready are seen here.
   always @(negedge clk) begin
      if (!rst && sign_valid === 1'b1 && sign_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL handshake: got code %0h, required no emission", sign_value);
         end else begin
            mon_exp = exp_q.pop_front();
            if (sign_value !== mon_exp) begin
               errors++;
               $display("FAIL handshake: got code %0h, required %0h", sign_value, mon_exp);
            end else begin
               $display("handshake: code %0h accepted at %0t", sign_value, $time);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_valid(input int budget, output int edges);
      edges = -1;
      for (int n = 1; n <= budget; n++) begin
         if (edges < 0) begin
            @(posedge clk);
            @(negedge clk);
            if (sign_valid === 1'b1) edges = n - 1;
         end
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++;
      if (sign_valid !== 1'b0 || sign_value !== 4'hF) begin
         errors++;
         $display("FAIL reset_state: valid=%b value=%h, required 0/f", sign_valid, sign_value);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      finger_status = 5'b00111;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (sign_valid !== 1'b0) begin
            errors++;
            $display("FAIL disabled_quiet: valid=%b, required 0", sign_valid);
         end
      end
      @(posedge clk); #1;
      finger_status = 5'b00000;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_basic;
      int e;
      @(posedge clk); #1;
      enable = 1'b1;
      finger_status = 5'b00111;
      exp_q.push_back(4'd3);
      wait_valid(20, e);
      checks++;
      if (e != N) begin
         errors++;
         $display("FAIL basic_latency: edges=%0d, required %0d", e, N);
      end
      checks++;
      if (sign_value !== 4'd3) begin
         errors++;
         $display("FAIL basic_value: value=%h, required 3", sign_value);
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if (sign_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_pulse: valid=%b one cycle after accept, required 0", sign_valid);
      end
   endtask

   task automatic test_classify;
      logic [NF-1:0] pats[3];
      logic [CW-1:0] codes[3];
      int e;
      pats  = '{5'b00101, 5'b00000, 5'b11111};
      codes = '{4'hF, 4'h0, 4'h5};
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         finger_status = pats[i];
         exp_q.push_back(codes[i]);
         wait_valid(20, e);
         checks++;
         if (e != N) begin
            errors++;
            $display("FAIL classify_latency %b: edges=%0d, required %0d", pats[i], e, N);
         end
         @(posedge clk); @(negedge clk);
         checks++;
         if (sign_valid !== 1'b0) begin
            errors++;
            $display("FAIL classify_pulse %b: valid=%b, required 0", pats[i], sign_valid);
         end
      end
   endtask

   task automatic test_glitch;
      int e;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         finger_status = (((c / 2) % 2) == 0) ? 5'b00001 : 5'b00011;
         @(negedge clk);
         checks++;
         if (sign_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_quiet: valid=%b at step %0d, required 0", sign_valid, c);
         end
      end
      exp_q.push_back(4'd2);
      wait_valid(20, e);
      checks++;
      if (e < 0) begin
         errors++;
         $display("FAIL glitch_settle: no valid within budget, required code 2");
      end
      @(posedge clk); #1;
      finger_status = 5'b00111;
      @(posedge clk); @(posedge clk); #1;
      finger_status = 5'b00011;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         checks++;
         if (sign_valid !== 1'b0) begin
            errors++;
            $display("FAIL repeat_no_reemit: valid=%b, required 0", sign_valid);
         end
      end
   endtask

   task automatic test_backpressure;
      int e;
      bit ok;
      @(posedge clk); #1;
      sign_ready = 1'b0;
      finger_status = 5'b00001;
      exp_q.push_back(4'd1);
      exp_q.push_back(4'd5);
      wait_valid(20, e);
      checks++;
      if (e != N) begin
         errors++;
         $display("FAIL stall_latency: edges=%0d, required %0d", e, N);
      end
      @(posedge clk); #1;
      finger_status = 5'b11111;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checks++;
         if (sign_valid !== 1'b1 || sign_value !== 4'd1) begin
            errors++;
            $display("FAIL stall_frozen: valid=%b value=%h, required 1/1", sign_valid, sign_value);
         end
      end
      @(posedge clk); #1;
      sign_ready = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (!ok) begin
            @(negedge clk);
            if (exp_q.size() == 0 && sign_valid === 1'b0) ok = 1'b1;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL stall_followup: %0d codes still pending, required 0", exp_q.size());
      end
   endtask

`ifdef GESTURE_HOLD_CNT_EN
   task automatic test_hold_cnt;
      int e;
      @(posedge clk); #1;
      finger_status = 5'b00001;
      exp_q.push_back(4'd1);
      wait_valid(20, e);
      @(posedge clk); @(negedge clk);
      checks++;
      if (hold_cycles !== 8'd0) begin
         errors++;
         $display("FAIL hold_clear: hold_cycles=%0d, required 0", hold_cycles);
      end
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         checks++;
         if (hold_cycles !== 8'(k)) begin
            errors++;
            $display("FAIL hold_count: hold_cycles=%0d, required %0d", hold_cycles, k);
         end
      end
      @(posedge clk); #1;
      finger_status = 5'b00011;
      exp_q.push_back(4'd2);
      wait_valid(20, e);
      @(posedge clk); @(negedge clk);
      checks++;
      if (hold_cycles !== 8'd0) begin
         errors++;
         $display("FAIL hold_reclear: hold_cycles=%0d, required 0", hold_cycles);
      end
   endtask
`endif

   task automatic test_enable;
      int e;
      @(posedge clk); #1;
      sign_ready = 1'b0;
      finger_status = 5'b00111;
      exp_q.push_back(4'd3);
      wait_valid(20, e);
      checks++;
      if (e != N) begin
         errors++;
         $display("FAIL enable_latency: edges=%0d, required %0d", e, N);
      end
      @(posedge clk); #1;
      enable = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (sign_valid !== 1'b1 || sign_value !== 4'd3) begin
            errors++;
            $display("FAIL enable_emit_hold: valid=%b value=%h, required 1/3", sign_valid, sign_value);
         end
      end
      @(posedge clk); #1;
      sign_ready = 1'b1;
      @(posedge clk); #1;
      finger_status = 5'b01111;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (sign_valid !== 1'b0) begin
            errors++;
            $display("FAIL enable_idle: valid=%b, required 0", sign_valid);
         end
      end
   endtask

   task automatic test_async_reset;
      int e;
      @(posedge clk); #1;
      sign_ready = 1'b0;
      enable = 1'b1;
      finger_status = 5'b00001;
      wait_valid(20, e);
      checks++;
      if (e != N) begin
         errors++;
         $display("FAIL rst_setup: edges=%0d, required %0d", e, N);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (sign_valid !== 1'b0 || sign_value !== 4'hF) begin
         errors++;
         $display("FAIL async_reset: valid=%b value=%h, required 0/f", sign_valid, sign_value);
      end
      enable = 1'b0;
      #2;
      rst = 1'b0;
      sign_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (sign_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_quiet: valid=%b, required 0", sign_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_classify();
      test_glitch();
      test_backpressure();
`ifdef GESTURE_HOLD_CNT_EN
      test_hold_cnt();
`endif
      test_enable();
      test_async_reset();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d codes never delivered, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
